// File: rtl/flip8.sv
// flip8: single-line Othello flip evaluator with a one-cycle registered result.
// Optional build macro FLIP8_OCCUPIED_CHECK_EN forces an all-zero result when cell pos is occupied.
module flip8 (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] player,
    input  logic [7:0] opponent,
    input  logic [2:0] pos,
    output logic [7:0] flip
);

    logic [7:0] ply_eff;
    logic [7:0] opp_eff;
    logic [7:0] up_mask;
    logic [7:0] dn_mask;
    logic [7:0] flip_d;
    logic [7:0] flip_q;

    // Scan toward bit 7: collect the opponent run that starts at pos+1 and
    // keep it only when a player stone closes it.
    function automatic logic [7:0] scan_up(input logic [7:0] ply,
                                           input logic [7:0] opp,
                                           input logic [2:0] p);
        logic [7:0] run;
        logic [7:0] res;
        logic       active;
        run    = '0;
        res    = '0;
        active = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > int'(p) && active) begin
                if (opp[i]) begin
                    run[i] = 1'b1;
                end else begin
                    active = 1'b0;
                    if (ply[i] && (|run))
                        res = run;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] scan_dn(input logic [7:0] ply,
                                           input logic [7:0] opp,
                                           input logic [2:0] p);
        logic [7:0] run;
        logic [7:0] res;
        logic       active;
        run    = '0;
        res    = '0;
        active = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i < int'(p) && active) begin
                if (opp[i]) begin
                    run[i] = 1'b1;
                end else begin
                    active = 1'b0;
                    if (ply[i] && (|run))
                        res = run;
                end
            end
        end
        return res;
    endfunction

    // Player ownership wins where both input masks claim a cell.
    assign ply_eff = player;
    assign opp_eff = opponent & ~player;

    assign up_mask = scan_up(ply_eff, opp_eff, pos);
    assign dn_mask = scan_dn(ply_eff, opp_eff, pos);

    always_comb begin
        flip_d = up_mask | dn_mask;
`ifdef FLIP8_OCCUPIED_CHECK_EN
        if (player[pos] | opponent[pos])
            flip_d = '0;
`endif
        flip_d[pos] = 1'b0;
    end

    // Output register stage
    always_ff @(posedge clock) begin
        if (reset)
            flip_q <= '0;
        else
            flip_q <= flip_d;
    end

    assign flip = flip_q;

endmodule

// File: tb/tb_flip8.sv
// Scoreboard bench for flip8: stimulus pushes expected results, a monitor pops and compares.
module tb_flip8;

    logic       clock;
    logic       reset;
    logic [7:0] player;
    logic [7:0] opponent;
    logic [2:0] pos;
    logic [7:0] flip;

    logic       in_vld;
    logic [7:0] exp_q[$];
    int         checks;
    int         errors;

    flip8 dut (
        .clock   (clock),
        .reset   (reset),
        .player  (player),
        .opponent(opponent),
        .pos     (pos),
        .flip    (flip)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: walk outward from pos with while loops.
    function automatic logic [7:0] model(input logic [7:0] p,
                                         input logic [7:0] o,
                                         input int ps);
        logic [7:0] oe;
        logic [7:0] m;
        logic [7:0] res;
        int j;
        oe  = o & ~p;
        res = 8'h00;
        m = 8'h00;
        j = ps + 1;
        while (j <= 7 && oe[j]) begin
            m[j] = 1'b1;
            j++;
        end
        if (j <= 7 && m != 8'h00 && p[j]) res = res | m;
        m = 8'h00;
        j = ps - 1;
        while (j >= 0 && oe[j]) begin
            m[j] = 1'b1;
            j--;
        end
        if (j >= 0 && m != 8'h00 && p[j]) res = res | m;
        return res;
    endfunction

    task automatic issue(input logic rst, input logic [7:0] p, input logic [7:0] o,
                         input logic [2:0] ps, input logic [7:0] e);
        @(negedge clock);
        reset    = rst;
        player   = p;
        opponent = o;
        pos      = ps;
        in_vld   = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge that sampled a valid vector yields one result.
    initial begin
        logic       sampled;
        logic [7:0] e;
        forever begin
            @(posedge clock);
            sampled = in_vld;
            #1;
            if (sampled) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow: flip=%h with no expected entry", flip);
                end else begin
                    e = exp_q.pop_front();
                    if (flip !== e) begin
                        errors++;
                        $display("FAIL flip_result: got %h expected %h (player=%h opponent=%h pos=%0d reset=%b)",
                                 flip, e, player, opponent, pos, reset);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] p, o, occ_exp;
        int code;
        checks   = 0;
        errors   = 0;
        in_vld   = 1'b0;
        reset    = 1'b1;
        player   = 8'h00;
        opponent = 8'h00;
        pos      = 3'd0;
        repeat (2) @(posedge clock);

        // Reset state with a flipping vector present.
        issue(1'b1, 8'h81, 8'h76, 3'd3, 8'h00);

        issue(1'b0, 8'h81, 8'h76, 3'd3, 8'h76);
        issue(1'b0, 8'h80, 8'h60, 3'd4, 8'h60);
        issue(1'b0, 8'h01, 8'h06, 3'd3, 8'h06);
        issue(1'b0, 8'h00, 8'h7E, 3'd0, 8'h00);
        issue(1'b0, 8'h80, 8'h50, 3'd3, 8'h00);
        issue(1'b0, 8'h00, 8'hF0, 3'd3, 8'h00);
        issue(1'b0, 8'h81, 8'hF7, 3'd3, 8'h76);
        issue(1'b0, 8'h00, 8'h7F, 3'd7, 8'h00);
        issue(1'b0, 8'h01, 8'h7E, 3'd7, 8'h7E);
        issue(1'b0, 8'h80, 8'h7E, 3'd0, 8'h7E);
        issue(1'b0, 8'h02, 8'h00, 3'd0, 8'h00);
`ifdef FLIP8_OCCUPIED_CHECK_EN
        occ_exp = 8'h00;
`else
        occ_exp = 8'h06;
`endif
        issue(1'b0, 8'h09, 8'h06, 3'd3, occ_exp);

        // Reset mid-stream, then recovery on the next edge.
        issue(1'b0, 8'h81, 8'h76, 3'd3, 8'h76);
        issue(1'b1, 8'h81, 8'h76, 3'd3, 8'h00);
        issue(1'b0, 8'h81, 8'h76, 3'd3, 8'h76);

        // Exhaustive: every pos, other seven cells each empty/player/opponent.
        for (int ps = 0; ps < 8; ps++) begin
            for (int c = 0; c < 2187; c++) begin
                p = 8'h00;
                o = 8'h00;
                code = c;
                for (int i = 0; i < 8; i++) begin
                    if (i != ps) begin
                        if (code % 3 == 1) p[i] = 1'b1;
                        else if (code % 3 == 2) o[i] = 1'b1;
                        code = code / 3;
                    end
                end
                issue(1'b0, p, o, 3'(ps), model(p, o, ps));
            end
        end

        @(negedge clock);
        in_vld = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
